acs_rx_unit: RTL and testbench



---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/acs_branch_metric.sv | 24 ++
 rtl/acs_rx_unit.sv | 117 +++++++++++
 tb/tb_acs_rx_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;

    localparam int K            = 3;
    localparam int PM_W_DEF     = 7;
    localparam int PATH_LEN_DEF = 8;
    localparam int SYM_W_DEF    = 1;

    // Code-bit pair expected on the branch from predecessor pred_idx (0 = pred 1, 1 = pred 2).
    function automatic logic [1:0] expected_pair(input logic [1:0] state, input logic pred_idx);
        logic [1:0] pair;
        case (state)
            2'b00:   pair = pred_idx ? 2'b11 : 2'b00;
            2'b01:   pair = pred_idx ? 2'b01 : 2'b10;
            2'b10:   pair = pred_idx ? 2'b00 : 2'b11;
            default: pair = pred_idx ? 2'b10 : 2'b01;
        endcase
        return pair;
    endfunction

    function automatic logic append_bit(input logic [1:0] state);
        return state[1];
    endfunction

endpackage

// File: rtl/acs_branch_metric.sv
// Branch metric for one trellis branch: summed per-code-bit distance, hard or soft decision.
module acs_branch_metric import viterbi_pkg::*; #(
    parameter int SYM_W = SYM_W_DEF
) (
    input  logic [2*SYM_W-1:0] data_recv,
    input  logic [1:0]         exp_pair,
    output logic [SYM_W:0]     bm
);

    localparam logic [SYM_W-1:0] SYM_MAX = '1;

    logic [SYM_W-1:0] sym_hi;
    logic [SYM_W-1:0] sym_lo;
    logic [SYM_W-1:0] dist_hi;
    logic [SYM_W-1:0] dist_lo;

    assign sym_hi  = data_recv[2*SYM_W-1:SYM_W];
    assign sym_lo  = data_recv[SYM_W-1:0];
    // Distance to an expected '1' is measured from the strongest '1' value.
    assign dist_hi = exp_pair[1] ? (SYM_MAX - sym_hi) : sym_hi;
    assign dist_lo = exp_pair[0] ? (SYM_MAX - sym_lo) : sym_lo;
    assign bm      = {1'b0, dist_hi} + {1'b0, dist_lo};

endmodule

// File: rtl/acs_rx_unit.sv
// Add-compare-select element with register-exchange survivor for one trellis state.
// Optional sticky overflow output ovf_flag is enabled by defining ACS_OVF_FLAG_EN.
module acs_rx_unit import viterbi_pkg::*; #(
    parameter int             PM_W     = PM_W_DEF,
    parameter int             PATH_LEN = PATH_LEN_DEF,
    parameter int             SYM_W    = SYM_W_DEF,
    parameter logic [K-2:0]   STATE_ID = '0,
    parameter logic [PM_W-1:0] INIT_PM = {1'b1, {(PM_W-1){1'b0}}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2*SYM_W-1:0]  data_recv,
    input  logic [PM_W-1:0]     pm_in_1,
    input  logic [PM_W-1:0]     pm_in_2,
    input  logic [PATH_LEN-1:0] path_in_1,
    input  logic [PATH_LEN-1:0] path_in_2,
    input  logic [PM_W-1:0]     norm_sub,
    output logic [PM_W-1:0]     pm_out,
    output logic [PATH_LEN-1:0] path_out,
    output logic                select_out,
    output logic                out_valid,
    output logic                fill_done,
    output logic                dec_bit
`ifdef ACS_OVF_FLAG_EN
    ,
    output logic                ovf_flag
`endif
);

    localparam int               CNT_W     = $clog2(PATH_LEN + 1);
    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(PATH_LEN);
    localparam logic [PM_W-1:0]  PM_MAX    = '1;
    localparam logic [PM_W-1:0]  RST_PM    = (STATE_ID == '0) ? '0 : INIT_PM;

    logic [SYM_W:0]      bm_1, bm_2;
    logic [PM_W:0]       sum_1, sum_2, chosen, diff;
    logic [PATH_LEN-1:0] path_chosen;
    logic                ovf_d;

    logic [PM_W-1:0]     pm_d, pm_q;
    logic [PATH_LEN-1:0] path_d, path_q;
    logic                sel_d, sel_q;
    logic                valid_q;
    logic [CNT_W-1:0]    cnt_q;

    acs_branch_metric #(.SYM_W(SYM_W)) u_bm_1 (
        .data_recv (data_recv),
        .exp_pair  (expected_pair(STATE_ID, 1'b0)),
        .bm        (bm_1)
    );

    acs_branch_metric #(.SYM_W(SYM_W)) u_bm_2 (
        .data_recv (data_recv),
        .exp_pair  (expected_pair(STATE_ID, 1'b1)),
        .bm        (bm_2)
    );

    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        sum_1       = {1'b0, pm_in_1} + (PM_W+1)'(bm_1);
        sum_2       = {1'b0, pm_in_2} + (PM_W+1)'(bm_2);
        // Equal sums fall back to the branch metric; equal metrics pick predecessor 2.
        sel_d       = (sum_1 > sum_2) || ((sum_1 == sum_2) && !(bm_1 < bm_2));
        chosen      = sel_d ? sum_2 : sum_1;
        path_chosen = sel_d ? path_in_2 : path_in_1;
        diff        = (chosen < {1'b0, norm_sub}) ? '0 : (chosen - {1'b0, norm_sub});
        ovf_d       = diff[PM_W];
        pm_d        = ovf_d ? PM_MAX : diff[PM_W-1:0];
        path_d      = {path_chosen[PATH_LEN-2:0], append_bit(STATE_ID)};
    end

    // NOTE: non-blocking updates so every register sees pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pm_q    <= RST_PM;
            path_q  <= '0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                pm_q   <= pm_d;
                path_q <= path_d;
                sel_q  <= sel_d;
                if (cnt_q != FILL_FULL) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef ACS_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            if (ovf_d) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ovf_flag = ovf_q;
`endif

    assign pm_out     = pm_q;
    assign path_out   = path_q;
    assign select_out = sel_q;
    assign out_valid  = valid_q;
    assign fill_done  = (cnt_q == FILL_FULL);
    assign dec_bit    = path_q[PATH_LEN-1];

endmodule

// File: tb/tb_acs_rx_unit.sv
// Directed bench for acs_rx_unit: hard-decision states 0/2/3 and a soft-decision state-0 instance.
module tb_acs_rx_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] data_recv;
    logic [5:0] data_recv_s;
    logic [6:0] pm_in_1, pm_in_2, norm_sub;
    logic [7:0] path_in_1, path_in_2;

    logic [6:0] pm0, pm2, pm3, pms;
    logic [7:0] path0, path2, path3, paths;
    logic       sel0, sel2, sel3, sels;
    logic       val0, val2, val3, vals;
    logic       fill0, fill2, fill3, fills;
    logic       dec0, dec2, dec3, decs;
`ifdef ACS_OVF_FLAG_EN
    logic       ovf0, ovf2, ovf3, ovfs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acs_rx_unit #(.STATE_ID(2'd0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_recv(data_recv),
        .pm_in_1(pm_in_1), .pm_in_2(pm_in_2), .path_in_1(path_in_1), .path_in_2(path_in_2),
        .norm_sub(norm_sub), .pm_out(pm0), .path_out(path0), .select_out(sel0),
        .out_valid(val0), .fill_done(fill0), .dec_bit(dec0)
`ifdef ACS_OVF_FLAG_EN
        , .ovf_flag(ovf0)
`endif
    );

    acs_rx_unit #(.STATE_ID(2'd2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_recv(data_recv),
        .pm_in_1(pm_in_1), .pm_in_2(pm_in_2), .path_in_1(path_in_1), .path_in_2(path_in_2),
        .norm_sub(norm_sub), .pm_out(pm2), .path_out(path2), .select_out(sel2),
        .out_valid(val2), .fill_done(fill2), .dec_bit(dec2)
`ifdef ACS_OVF_FLAG_EN
        , .ovf_flag(ovf2)
`endif
    );

    acs_rx_unit #(.STATE_ID(2'd3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_recv(data_recv),
        .pm_in_1(pm_in_1), .pm_in_2(pm_in_2), .path_in_1(path_in_1), .path_in_2(path_in_2),
        .norm_sub(norm_sub), .pm_out(pm3), .path_out(path3), .select_out(sel3),
        .out_valid(val3), .fill_done(fill3), .dec_bit(dec3)
`ifdef ACS_OVF_FLAG_EN
        , .ovf_flag(ovf3)
`endif
    );

    acs_rx_unit #(.SYM_W(3), .STATE_ID(2'd0)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_recv(data_recv_s),
        .pm_in_1(pm_in_1), .pm_in_2(pm_in_2), .path_in_1(path_in_1), .path_in_2(path_in_2),
        .norm_sub(norm_sub), .pm_out(pms), .path_out(paths), .select_out(sels),
        .out_valid(vals), .fill_done(fills), .dec_bit(decs)
`ifdef ACS_OVF_FLAG_EN
        , .ovf_flag(ovfs)
`endif
    );

    typedef struct {
        logic       valid;
        logic [1:0] data;
        logic [6:0] pm1, pm2;
        logic [7:0] p1, p2;
        logic [6:0] norm;
        logic [6:0] e0_pm;
        logic [7:0] e0_path;
        logic       e0_sel;
        logic [6:0] e3_pm;
        logic [7:0] e3_path;
        logic       e3_sel;
        logic       e_valid;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_beat(input logic [1:0] d, input logic [6:0] a, input logic [6:0] b,
                             input logic [7:0] pa, input logic [7:0] pb);
        in_valid  = 1'b1;
        data_recv = d;
        pm_in_1   = a;
        pm_in_2   = b;
        path_in_1 = pa;
        path_in_2 = pb;
        norm_sub  = 7'd0;
        step();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        data_recv = 'x;
        pm_in_1   = 'x;
        pm_in_2   = 'x;
        step();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step();
        rst      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] exp_path;

        vecs[0]  = '{1'b1, 2'b00,   7'd3,   7'd3, 8'h5A, 8'hFF, 7'd0,   7'd3, 8'hB4, 1'b0,   7'd4, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'b00,   7'd3,   7'd3, 8'h5A, 8'hFF, 7'd3,   7'd0, 8'hB4, 1'b0,   7'd1, 8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'b01,   7'd4,   7'd4, 8'h5A, 8'hFF, 7'd0,   7'd5, 8'hFE, 1'b1,   7'd4, 8'hB5, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 7'd127, 7'd127, 8'h5A, 8'hFF, 7'd0, 7'd127, 8'hFE, 1'b1, 7'd127, 8'hB5, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 2'b11,  7'd10,   7'd2, 8'h0F, 8'hF0, 7'd0,   7'd2, 8'hE0, 1'b1,   7'd3, 8'hE1, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 2'b10,   7'd1,   7'd9, 8'h81, 8'h3C, 7'd1,   7'd1, 8'h02, 1'b0,   7'd2, 8'h03, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 2'b00,   7'd0,   7'd0, 8'h81, 8'h3C, 7'd5,   7'd0, 8'h02, 1'b0,   7'd0, 8'h79, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 7'd126, 7'd127, 8'h81, 8'h3C, 7'd0, 7'd126, 8'h02, 1'b0, 7'd127, 8'h03, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 2'b11, 7'd127, 7'd127, 8'h81, 8'h3C, 7'd2, 7'd125, 8'h78, 1'b1, 7'd126, 8'h79, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0,    'x,     'x,     'x,    'x,    'x,   'x, 7'd125, 8'h78, 1'b1, 7'd126, 8'h79, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b10,  7'd20,  7'd20, 8'h5A, 8'hFF, 7'd0,  7'd21, 8'hFE, 1'b1,  7'd20, 8'hFF, 1'b1, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; data_recv = 2'b00; data_recv_s = 6'd0;
        pm_in_1 = 7'd0; pm_in_2 = 7'd0; path_in_1 = 8'h00; path_in_2 = 8'h00; norm_sub = 7'd0;
        step();
        do_reset();

        check("rst pm0", pm0, 7'd0);
        check("rst path0", path0, 8'h00);
        check("rst sel0", sel0, 1'b0);
        check("rst valid0", val0, 1'b0);
        check("rst fill0", fill0, 1'b0);
        check("rst pm2", pm2, 7'd64);
        check("rst pm3", pm3, 7'd64);
        check("rst pm_soft", pms, 7'd0);
`ifdef ACS_OVF_FLAG_EN
        check("rst ovf0", ovf0, 1'b0);
`endif

        foreach (vecs[i]) begin
            in_valid  = vecs[i].valid;
            data_recv = vecs[i].data;
            pm_in_1   = vecs[i].pm1;
            pm_in_2   = vecs[i].pm2;
            path_in_1 = vecs[i].p1;
            path_in_2 = vecs[i].p2;
            norm_sub  = vecs[i].norm;
            step();
            check($sformatf("v%0d pm0", i), pm0, vecs[i].e0_pm);
            check($sformatf("v%0d path0", i), path0, vecs[i].e0_path);
            check($sformatf("v%0d sel0", i), sel0, vecs[i].e0_sel);
            check($sformatf("v%0d pm3", i), pm3, vecs[i].e3_pm);
            check($sformatf("v%0d path3", i), path3, vecs[i].e3_path);
            check($sformatf("v%0d sel3", i), sel3, vecs[i].e3_sel);
            check($sformatf("v%0d valid0", i), val0, vecs[i].e_valid);
            check($sformatf("v%0d valid3", i), val3, vecs[i].e_valid);
`ifdef ACS_OVF_FLAG_EN
            check($sformatf("v%0d ovf0", i), ovf0, vecs[i].e_ovf);
            check($sformatf("v%0d ovf3", i), ovf3, 1'b0);
`endif
        end

        // Soft decision, 3-bit symbols, state 0.
        in_valid = 1'b1; data_recv = 2'b00; norm_sub = 7'd0;
        pm_in_1 = 7'd0; pm_in_2 = 7'd0; path_in_1 = 8'h5A; path_in_2 = 8'hFF;
        data_recv_s = {3'd7, 3'd0};
        step();
        check("soft tie sel", sels, 1'b1);
        check("soft tie pm", pms, 7'd7);
        check("soft tie path", paths, 8'hFE);
        check("soft tie valid", vals, 1'b1);
        data_recv_s = {3'd1, 3'd2};
        step();
        check("soft near0 sel", sels, 1'b0);
        check("soft near0 pm", pms, 7'd3);
        check("soft near0 path", paths, 8'hB4);
        data_recv_s = {3'd7, 3'd7};
        step();
        check("soft strong1 sel", sels, 1'b1);
        check("soft strong1 pm", pms, 7'd0);

        // Fill counter with idle gaps after beats 2, 4 and 6.
        do_reset();
        exp_path = 8'h00;
        for (int b = 1; b <= 9; b++) begin
            pat      = 8'(b * 37 + 5);
            exp_path = {pat[6:0], 1'b0};
            hard_beat(2'b00, 7'd0, 7'd0, pat, 8'h00);
            check($sformatf("fill b%0d path", b), path0, exp_path);
            check($sformatf("fill b%0d done", b), fill0, (b >= 8) ? 1'b1 : 1'b0);
            check($sformatf("fill b%0d dec", b), dec0, pat[6]);
            if (b == 2 || b == 4 || b == 6) begin
                idle();
                check($sformatf("idle b%0d valid", b), val0, 1'b0);
                check($sformatf("idle b%0d path", b), path0, exp_path);
                check($sformatf("idle b%0d pm", b), pm0, 7'd0);
                check($sformatf("idle b%0d done", b), fill0, 1'b0);
            end
        end

        // Reset asserted together with a valid beat drops that beat and clears the count.
        do_reset();
        for (int b = 1; b <= 4; b++) begin
            hard_beat(2'b01, 7'd9, 7'd9, 8'hAA, 8'h55);
        end
        rst = 1'b1;
        hard_beat(2'b11, 7'd30, 7'd40, 8'hC3, 8'h3C);
        rst = 1'b0;
        check("rst beat pm0", pm0, 7'd0);
        check("rst beat path0", path0, 8'h00);
        check("rst beat valid0", val0, 1'b0);
        check("rst beat fill0", fill0, 1'b0);
        check("rst beat pm2", pm2, 7'd64);
        for (int b = 1; b <= 8; b++) begin
            hard_beat(2'b00, 7'd1, 7'd1, 8'h01, 8'h02);
            if (b == 7) check("refill b7 done", fill0, 1'b0);
            if (b == 8) check("refill b8 done", fill0, 1'b1);
        end
        check("refill state2 path", path2, 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
